// File: rtl/regfile_pkg.sv
// Shared definitions for the integer register-file write scoreboard.
//   NUM_REGS   architectural registers tracked (x0 hardwired, never pending)
//   ADDR_W     register address width
//   CNT_W      per-register in-flight counter width
//   reg_addr_t register index type
//   sb_cnt_t   in-flight write counter type
//   SB_CNT_MAX saturation value of an in-flight counter
package regfile_pkg;

  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned CNT_W    = 2;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [CNT_W-1:0]  sb_cnt_t;

  localparam sb_cnt_t SB_CNT_MAX = '1;

endpackage

// File: rtl/sb_entry.sv
// One scoreboard entry: in-flight write counter for a single register.
// Ports:
//   clk_i        pipeline clock
//   rst_i        asynchronous reset, active-high
//   inc_i        a write to this register was issued
//   dec_i        a write to this register retired in writeback
//   cnt_o        current number of outstanding writes
//   busy_o       cnt_o != 0
//   underflow_o  writeback arrived while no write was outstanding
module sb_entry
  import regfile_pkg::*;
(
  input  logic    clk_i,
  input  logic    rst_i,
  input  logic    inc_i,
  input  logic    dec_i,
  output sb_cnt_t cnt_o,
  output logic    busy_o,
  output logic    underflow_o
);

  sb_cnt_t cnt_q;

  // A writeback hitting an empty counter is discarded, so a simultaneous
  // issue still counts; otherwise increment and decrement cancel.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (inc_i && !dec_i && cnt_q != SB_CNT_MAX) begin
      cnt_q <= cnt_q + sb_cnt_t'(1);
    end else if (dec_i && !inc_i && cnt_q != '0) begin
      cnt_q <= cnt_q - sb_cnt_t'(1);
    end else if (inc_i && dec_i && cnt_q == '0) begin
      cnt_q <= sb_cnt_t'(1);
    end
  end

  assign cnt_o       = cnt_q;
  assign busy_o      = (cnt_q != '0);
  assign underflow_o = dec_i & (cnt_q == '0);

endmodule

// File: rtl/regfile_scoreboard.sv
// Hazard-tracking scoreboard for the register-file write side of the
// non-forwarding pipeline. Counts in-flight writes per destination from
// issue to writeback and stalls decode on a pending source or a full counter.
// Optional feature macro: SCOREBOARD_WB_BYPASS_EN -- a source whose last
// outstanding write is in writeback this cycle is not hazardous (regfile
// write-through read).
// Ports:
//   clk_i, rst_i                  clock, asynchronous active-high reset
//   issue_valid_i                 ID instruction attempting issue
//   issue_rd_wren_i/_addr_i       issuing instruction's destination
//   rs1_used_i/rs1_addr_i         source 1
//   rs2_used_i/rs2_addr_i         source 2
//   flush_i                       ID instruction squashed
//   wb_valid_i/wb_rd_addr_i       writeback register write
//   stall_o                       hold IF/ID, bubble EX (combinational)
//   pending_o                     per-register counter != 0
//   err_o                         sticky writeback-without-pending-write flag
module regfile_scoreboard
  import regfile_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                issue_valid_i,
  input  logic                issue_rd_wren_i,
  input  logic [ADDR_W-1:0]   issue_rd_addr_i,
  input  logic                rs1_used_i,
  input  logic [ADDR_W-1:0]   rs1_addr_i,
  input  logic                rs2_used_i,
  input  logic [ADDR_W-1:0]   rs2_addr_i,
  input  logic                flush_i,
  input  logic                wb_valid_i,
  input  logic [ADDR_W-1:0]   wb_rd_addr_i,
  output logic                stall_o,
  output logic [NUM_REGS-1:0] pending_o,
  output logic                err_o
);

  sb_cnt_t               cnt [NUM_REGS];
  logic [NUM_REGS-1:0]   busy;
  logic [NUM_REGS-1:1]   inc;
  logic [NUM_REGS-1:1]   dec;
  logic [NUM_REGS-1:1]   uflow;
  logic                  res1, res2;
  logic                  haz1, haz2, full;
  logic                  accept;
  logic                  err_q;

  assign cnt[0]  = '0;
  assign busy[0] = 1'b0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
    sb_entry u_entry (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .inc_i       (inc[r]),
      .dec_i       (dec[r]),
      .cnt_o       (cnt[r]),
      .busy_o      (busy[r]),
      .underflow_o (uflow[r])
    );
  end

`ifdef SCOREBOARD_WB_BYPASS_EN
  assign res1 = wb_valid_i && wb_rd_addr_i == rs1_addr_i && cnt[rs1_addr_i] == sb_cnt_t'(1);
  assign res2 = wb_valid_i && wb_rd_addr_i == rs2_addr_i && cnt[rs2_addr_i] == sb_cnt_t'(1);
`else
  assign res1 = 1'b0;
  assign res2 = 1'b0;
`endif

  // cnt[0] is constant zero, so x0 can never be hazardous or full.
  assign haz1 = rs1_used_i && rs1_addr_i != '0 && cnt[rs1_addr_i] != '0 && !res1;
  assign haz2 = rs2_used_i && rs2_addr_i != '0 && cnt[rs2_addr_i] != '0 && !res2;
  assign full = issue_rd_wren_i && issue_rd_addr_i != '0 &&
                cnt[issue_rd_addr_i] == SB_CNT_MAX;

  assign stall_o = issue_valid_i & ~flush_i & (haz1 | haz2 | full);
  assign accept  = issue_valid_i & ~flush_i & ~stall_o;

  always_comb begin
    inc = '0;
    dec = '0;
    for (int unsigned r = 1; r < NUM_REGS; r++) begin
      inc[r] = accept && issue_rd_wren_i && issue_rd_addr_i == reg_addr_t'(r);
      dec[r] = wb_valid_i && wb_rd_addr_i == reg_addr_t'(r);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else if (|uflow) begin
      err_q <= 1'b1;
    end
  end

  assign pending_o = busy;
  assign err_o     = err_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
module tb_regfile_scoreboard;
  import regfile_pkg::*;

  logic                clk_i = 1'b0;
  logic                rst_i;
  logic                issue_valid_i, issue_rd_wren_i;
  logic [ADDR_W-1:0]   issue_rd_addr_i;
  logic                rs1_used_i, rs2_used_i;
  logic [ADDR_W-1:0]   rs1_addr_i, rs2_addr_i;
  logic                flush_i, wb_valid_i;
  logic [ADDR_W-1:0]   wb_rd_addr_i;
  logic                stall_o;
  logic [NUM_REGS-1:0] pending_o;
  logic                err_o;

`ifdef SCOREBOARD_WB_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  typedef struct {
    int                  id;
    logic                stall;
    logic [NUM_REGS-1:0] pend;
    logic                err;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   vec_n  = 0;
  logic done   = 1'b0;

  regfile_scoreboard dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .issue_valid_i   (issue_valid_i),
    .issue_rd_wren_i (issue_rd_wren_i),
    .issue_rd_addr_i (issue_rd_addr_i),
    .rs1_used_i      (rs1_used_i),
    .rs1_addr_i      (rs1_addr_i),
    .rs2_used_i      (rs2_used_i),
    .rs2_addr_i      (rs2_addr_i),
    .flush_i         (flush_i),
    .wb_valid_i      (wb_valid_i),
    .wb_rd_addr_i    (wb_rd_addr_i),
    .stall_o         (stall_o),
    .pending_o       (pending_o),
    .err_o           (err_o)
  );

  always #5 clk_i = ~clk_i;

  // One vector per cycle: inputs applied just after the rising edge, the
  // expected outputs for that cycle queued for the monitor.
  task automatic step(input logic rst, input logic v, input logic wr, input int rd,
                      input logic u1, input int a1, input logic u2, input int a2,
                      input logic fl, input logic wv, input int wa,
                      input logic e_stall, input logic [NUM_REGS-1:0] e_pend,
                      input logic e_err);
    exp_t e;
    @(posedge clk_i);
    #1;
    rst_i           = rst;
    issue_valid_i   = v;
    issue_rd_wren_i = wr;
    issue_rd_addr_i = ADDR_W'(rd);
    rs1_used_i      = u1;
    rs1_addr_i      = ADDR_W'(a1);
    rs2_used_i      = u2;
    rs2_addr_i      = ADDR_W'(a2);
    flush_i         = fl;
    wb_valid_i      = wv;
    wb_rd_addr_i    = ADDR_W'(wa);
    vec_n++;
    e.id    = vec_n;
    e.stall = e_stall;
    e.pend  = e_pend;
    e.err   = e_err;
    q.push_back(e);
  endtask

  function automatic logic [NUM_REGS-1:0] b(input int r);
    logic [NUM_REGS-1:0] m;
    m = '0;
    m[r] = 1'b1;
    return m;
  endfunction

  // Monitor: compares DUT outputs against the queued expectation mid-cycle.
  always @(negedge clk_i) begin
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (stall_o !== e.stall) begin
        errors++;
        $display("FAIL stall vec%0d got %b exp %b", e.id, stall_o, e.stall);
      end
      checks++;
      if (pending_o !== e.pend) begin
        errors++;
        $display("FAIL pending vec%0d got %h exp %h", e.id, pending_o, e.pend);
      end
      checks++;
      if (err_o !== e.err) begin
        errors++;
        $display("FAIL err vec%0d got %b exp %b", e.id, err_o, e.err);
      end
    end
  end

  initial begin
    rst_i = 1'b1;
    issue_valid_i = 0; issue_rd_wren_i = 0; issue_rd_addr_i = '0;
    rs1_used_i = 0; rs1_addr_i = '0; rs2_used_i = 0; rs2_addr_i = '0;
    flush_i = 0; wb_valid_i = 0; wb_rd_addr_i = '0;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;

    //   rst v  wr rd  u1 a1  u2 a2  fl wv wa   stall pend err
    step(0, 0, 0, 0,  0, 0,  0, 0,  0, 0, 0,   0, '0, 0);      // reset state
    // dependent read on rd=5
    step(0, 1, 1, 5,  0, 0,  0, 0,  0, 0, 0,   0, '0, 0);
    step(0, 1, 0, 0,  1, 5,  0, 0,  0, 0, 0,   1, b(5), 0);
    step(0, 1, 0, 0,  1, 5,  0, 0,  0, 1, 5,   !BYP, b(5), 0);
    step(0, 1, 0, 0,  1, 5,  0, 0,  0, 0, 0,   0, '0, 0);
    // x0 everywhere, including a writeback to x0
    step(0, 1, 1, 0,  1, 0,  1, 0,  0, 1, 0,   0, '0, 0);
    step(0, 1, 1, 0,  1, 0,  1, 0,  0, 0, 0,   0, '0, 0);
    // saturate rd=7
    step(0, 1, 1, 7,  0, 0,  0, 0,  0, 0, 0,   0, '0, 0);
    step(0, 1, 1, 7,  0, 0,  0, 0,  0, 0, 0,   0, b(7), 0);
    step(0, 1, 1, 7,  0, 0,  0, 0,  0, 0, 0,   0, b(7), 0);
    step(0, 1, 1, 7,  0, 0,  0, 0,  0, 0, 0,   1, b(7), 0);     // count 3: full
    step(0, 1, 1, 7,  0, 0,  0, 0,  0, 1, 7,   1, b(7), 0);     // no full bypass via wb
    step(0, 1, 1, 7,  0, 0,  0, 0,  0, 0, 0,   0, b(7), 0);     // count 2: issues
    step(0, 0, 0, 0,  0, 0,  0, 0,  0, 1, 7,   0, b(7), 0);     // 3 -> 2
    step(0, 1, 0, 0,  0, 0,  1, 7,  0, 1, 7,   1, b(7), 0);     // rs2 hazard, 2 -> 1
    step(0, 1, 0, 0,  0, 0,  1, 7,  0, 1, 7,   !BYP, b(7), 0);  // last wb, 1 -> 0
    step(0, 0, 0, 0,  0, 0,  0, 0,  0, 0, 0,   0, '0, 0);
    // same-cycle issue and writeback on rd=9
    step(0, 1, 1, 9,  0, 0,  0, 0,  0, 0, 0,   0, '0, 0);
    step(0, 1, 1, 9,  0, 0,  0, 0,  0, 1, 9,   0, b(9), 0);
    step(0, 0, 0, 0,  0, 0,  0, 0,  0, 0, 0,   0, b(9), 0);
    step(0, 0, 0, 0,  0, 0,  0, 0,  0, 1, 9,   0, b(9), 0);
    step(0, 0, 0, 0,  0, 0,  0, 0,  0, 0, 0,   0, '0, 0);
    // spurious writeback, then flush over a hazard
    step(0, 0, 0, 0,  0, 0,  0, 0,  0, 1, 12,  0, '0, 0);
    step(0, 0, 0, 0,  0, 0,  0, 0,  0, 0, 0,   0, '0, 1);
    step(0, 1, 1, 3,  0, 0,  0, 0,  0, 0, 0,   0, '0, 1);
    step(0, 1, 1, 3,  1, 3,  0, 0,  1, 0, 0,   0, b(3), 1);
    step(0, 0, 0, 0,  0, 0,  0, 0,  0, 0, 0,   0, b(3), 1);     // still count 1
    step(0, 0, 0, 0,  0, 0,  0, 0,  0, 1, 3,   0, b(3), 1);
    step(0, 0, 0, 0,  0, 0,  0, 0,  0, 0, 0,   0, '0, 1);
    // asynchronous reset while stalled
    step(0, 1, 1, 4,  0, 0,  0, 0,  0, 0, 0,   0, '0, 1);
    step(0, 1, 0, 0,  1, 4,  0, 0,  0, 0, 0,   1, b(4), 1);
    step(1, 1, 0, 0,  1, 4,  0, 0,  0, 0, 0,   0, '0, 0);
    step(0, 1, 0, 0,  1, 4,  0, 0,  0, 0, 0,   0, '0, 0);

    for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk_i);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain left %0d exp 0", q.size());
    end
    if (checks == 0) begin
      errors++;
      $display("FAIL nochecks got 0 exp >0");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
